// File: rtl/model_ntm_pkg.sv
// Shared constants for the NTM model blocks: FSM state encoding and
// single-bit control levels.
package model_ntm_pkg;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

  localparam logic [1:0] STATE_IDLE    = 2'd0;
  localparam logic [1:0] STATE_LOAD    = 2'd1;
  localparam logic [1:0] STATE_COMPUTE = 2'd2;
  localparam logic [1:0] STATE_DRAIN   = 2'd3;

endpackage

// File: rtl/model_scalar_fixed_divider.sv
// Sequential signed integer divider: restoring division on magnitudes, one
// quotient bit per cycle, quotient truncated toward zero.
module model_scalar_fixed_divider
  import model_ntm_pkg::*;
#(
  parameter int DATA_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic                 READY,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int CW = $clog2(DATA_SIZE + 1);

  logic                 busy;
  logic                 neg;
  logic [CW-1:0]        count;
  logic [DATA_SIZE-1:0] rem;
  logic [DATA_SIZE-1:0] quo;
  logic [DATA_SIZE-1:0] divisor;
  logic [DATA_SIZE-1:0] abs_a;
  logic [DATA_SIZE-1:0] abs_b;
  logic [DATA_SIZE-1:0] q_next;
  logic [DATA_SIZE-1:0] r_next;
  logic [DATA_SIZE:0]   shifted;
  logic [DATA_SIZE:0]   diff;

  // The borrow bit of the trial subtraction decides the next quotient bit.
  always_comb begin
    abs_a   = DATA_A_IN[DATA_SIZE-1] ? -DATA_A_IN : DATA_A_IN;
    abs_b   = DATA_B_IN[DATA_SIZE-1] ? -DATA_B_IN : DATA_B_IN;
    shifted = {rem, quo[DATA_SIZE-1]};
    diff    = shifted - {ZERO, divisor};
    if (!diff[DATA_SIZE]) begin
      r_next = diff[DATA_SIZE-1:0];
      q_next = {quo[DATA_SIZE-2:0], ONE};
    end else begin
      r_next = shifted[DATA_SIZE-1:0];
      q_next = {quo[DATA_SIZE-2:0], ZERO};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy     <= ZERO;
      neg      <= ZERO;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      divisor  <= '0;
      READY    <= ZERO;
      DATA_OUT <= '0;
    end else begin
      READY <= ZERO;
      if (START) begin
        busy    <= ONE;
        neg     <= DATA_A_IN[DATA_SIZE-1] ^ DATA_B_IN[DATA_SIZE-1];
        count   <= CW'(DATA_SIZE);
        rem     <= '0;
        quo     <= abs_a;
        divisor <= abs_b;
      end else if (busy) begin
        rem   <= r_next;
        quo   <= q_next;
        count <= count - CW'(1);
        if (count == CW'(1)) begin
          busy     <= ZERO;
          READY    <= ONE;
          DATA_OUT <= neg ? -q_next : q_next;
        end
      end
    end
  end

endmodule

// File: rtl/model_vector_fixed_lane_divider.sv
// Vector divider: gathers up to LANES operand pairs per batch, divides them
// in parallel scalar lanes, then streams the quotients out in input order.
module model_vector_fixed_lane_divider
  import model_ntm_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int LANES        = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic                 DATA_A_IN_ENABLE,
  input  logic                 DATA_B_IN_ENABLE,
  output logic                 DATA_OUT_ENABLE,
  output logic                 DIV_ZERO,
  input  logic [DATA_SIZE-1:0] SIZE_IN,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int SW = $clog2(LANES + 1);
  localparam logic [DATA_SIZE-1:0] SAT_POS = {ZERO, {(DATA_SIZE-1){ONE}}};
  localparam logic [DATA_SIZE-1:0] SAT_NEG = {ONE, {(DATA_SIZE-1){ZERO}}};

  logic [1:0]              state;
  logic [CONTROL_SIZE-1:0] size_reg;
  logic [CONTROL_SIZE-1:0] loaded_cnt;
  logic [SW-1:0]           slot;
  logic [SW-1:0]           batch_k;
  logic [SW-1:0]           drain_idx;
  logic                    a_held;
  logic                    b_held;
  logic                    entry;
  logic                    a_take;
  logic                    b_take;
  logic                    slot_complete;
  logic                    all_done;
  logic [DATA_SIZE-1:0]    drain_data;
  logic [DATA_SIZE-1:0]    a_hold   [LANES];
  logic [DATA_SIZE-1:0]    b_hold   [LANES];
  logic [DATA_SIZE-1:0]    result   [LANES];
  logic [DATA_SIZE-1:0]    lane_out [LANES];
  logic [LANES-1:0]        done;
  logic [LANES-1:0]        in_batch;
  logic [LANES-1:0]        lane_zero;
  logic [LANES-1:0]        lane_start;
  logic [LANES-1:0]        lane_ready;

  // Lane starts fire only in the first COMPUTE cycle, once the hold registers are settled.
  always_comb begin
    a_take        = DATA_A_IN_ENABLE && !a_held;
    b_take        = DATA_B_IN_ENABLE && !b_held;
    slot_complete = (a_held || a_take) && (b_held || b_take);
    all_done      = ONE;
    drain_data    = '0;
    for (int i = 0; i < LANES; i++) begin
      in_batch[i]   = SW'(i) < batch_k;
      lane_zero[i]  = (b_hold[i] == '0);
      lane_start[i] = entry && in_batch[i] && !lane_zero[i];
      if (in_batch[i] && !done[i]) all_done = ZERO;
      if (drain_idx == SW'(i)) drain_data = result[i];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    model_scalar_fixed_divider #(
      .DATA_SIZE(DATA_SIZE)
    ) u_divider (
      .CLK      (CLK),
      .RST      (RST),
      .START    (lane_start[g]),
      .DATA_A_IN(a_hold[g]),
      .DATA_B_IN(b_hold[g]),
      .READY    (lane_ready[g]),
      .DATA_OUT (lane_out[g])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= STATE_IDLE;
      size_reg        <= '0;
      loaded_cnt      <= '0;
      slot            <= '0;
      batch_k         <= '0;
      drain_idx       <= '0;
      a_held          <= ZERO;
      b_held          <= ZERO;
      entry           <= ZERO;
      done            <= '0;
      READY           <= ZERO;
      DATA_OUT_ENABLE <= ZERO;
      DIV_ZERO        <= ZERO;
      DATA_OUT        <= '0;
      for (int i = 0; i < LANES; i++) begin
        a_hold[i] <= '0;
        b_hold[i] <= '0;
        result[i] <= '0;
      end
    end else begin
      READY           <= ZERO;
      DATA_OUT_ENABLE <= ZERO;
      case (state)
        STATE_IDLE: begin
          if (START) begin
            size_reg   <= CONTROL_SIZE'(SIZE_IN);
            loaded_cnt <= '0;
            slot       <= '0;
            a_held     <= ZERO;
            b_held     <= ZERO;
            done       <= '0;
            DIV_ZERO   <= ZERO;
            if (SIZE_IN == '0) READY <= ONE;
            else state <= STATE_LOAD;
          end
        end
        STATE_LOAD: begin
          for (int i = 0; i < LANES; i++) begin
            if (slot == SW'(i)) begin
              if (a_take) a_hold[i] <= DATA_A_IN;
              if (b_take) b_hold[i] <= DATA_B_IN;
            end
          end
          if (slot_complete) begin
            a_held     <= ZERO;
            b_held     <= ZERO;
            slot       <= slot + SW'(1);
            loaded_cnt <= loaded_cnt + CONTROL_SIZE'(1);
            if (slot == SW'(LANES - 1) || loaded_cnt + CONTROL_SIZE'(1) == size_reg) begin
              batch_k <= slot + SW'(1);
              entry   <= ONE;
              state   <= STATE_COMPUTE;
            end
          end else begin
            a_held <= a_held || a_take;
            b_held <= b_held || b_take;
          end
        end
        STATE_COMPUTE: begin
          entry <= ZERO;
          // Zero divisors never start their lane; they saturate toward the dividend's sign.
          for (int i = 0; i < LANES; i++) begin
            if (entry && in_batch[i] && lane_zero[i]) begin
              done[i]   <= ONE;
              result[i] <= a_hold[i][DATA_SIZE-1] ? SAT_NEG : SAT_POS;
              DIV_ZERO  <= ONE;
            end
            if (lane_ready[i]) begin
              done[i]   <= ONE;
              result[i] <= lane_out[i];
            end
          end
          if (!entry && all_done) begin
            drain_idx <= '0;
            state     <= STATE_DRAIN;
          end
        end
        STATE_DRAIN: begin
          DATA_OUT        <= drain_data;
          DATA_OUT_ENABLE <= ONE;
          drain_idx       <= drain_idx + SW'(1);
          if (drain_idx == batch_k - SW'(1)) begin
            done <= '0;
            slot <= '0;
            if (loaded_cnt == size_reg) begin
              READY <= ONE;
              state <= STATE_IDLE;
            end else begin
              state <= STATE_LOAD;
            end
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_model_vector_fixed_lane_divider.sv
// Directed bench for the vector lane divider; quotients are signed integer
// division truncated toward zero, with saturation on a zero divisor.
module tb_model_vector_fixed_lane_divider;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        READY;
  logic        DATA_A_IN_ENABLE;
  logic        DATA_B_IN_ENABLE;
  logic        DATA_OUT_ENABLE;
  logic        DIV_ZERO;
  logic [15:0] SIZE_IN;
  logic [15:0] DATA_A_IN;
  logic [15:0] DATA_B_IN;
  logic [15:0] DATA_OUT;

  int testCount = 0;
  int failCount = 0;
  int readyCount = 0;
  int readyWithOutCount = 0;
  logic [15:0] outQ [$];
  int base;
  int rbase;
  int wbase;

  logic [15:0] vecA [4] = '{16'h0400, 16'h0800, 16'hF800, 16'h0100};
  logic [15:0] vecB [4] = '{16'h0200, 16'h0400, 16'h0200, 16'h0100};
  logic [15:0] vecQ [4] = '{16'h0002, 16'h0002, 16'hFFFC, 16'h0001};
  logic [15:0] sixA [6] = '{16'h0064, 16'hFF9C, 16'h7FFF, 16'h0100, 16'h0005, 16'h8000};
  logic [15:0] sixB [6] = '{16'h0007, 16'h0007, 16'h0002, 16'hFFFF, 16'h0009, 16'h0001};
  logic [15:0] sixQ [6] = '{16'h000E, 16'hFFF2, 16'h3FFF, 16'hFF00, 16'h0000, 16'h8000};

  model_vector_fixed_lane_divider #(
    .DATA_SIZE   (16),
    .CONTROL_SIZE(16),
    .LANES       (4)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .START           (START),
    .READY           (READY),
    .DATA_A_IN_ENABLE(DATA_A_IN_ENABLE),
    .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE),
    .DATA_OUT_ENABLE (DATA_OUT_ENABLE),
    .DIV_ZERO        (DIV_ZERO),
    .SIZE_IN         (SIZE_IN),
    .DATA_A_IN       (DATA_A_IN),
    .DATA_B_IN       (DATA_B_IN),
    .DATA_OUT        (DATA_OUT)
  );

  always #5 CLK = ~CLK;

  // Output monitor samples on the falling edge, away from the register updates.
  always @(negedge CLK) begin
    if (DATA_OUT_ENABLE) outQ.push_back(DATA_OUT);
    if (READY) begin
      readyCount <= readyCount + 1;
      if (DATA_OUT_ENABLE) readyWithOutCount <= readyWithOutCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic aEn, input logic [15:0] a, input logic bEn, input logic [15:0] b);
    DATA_A_IN_ENABLE = aEn;
    DATA_A_IN        = a;
    DATA_B_IN_ENABLE = bEn;
    DATA_B_IN        = b;
    @(posedge CLK);
    #1;
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN_ENABLE = 1'b0;
  endtask

  task automatic startVector(input logic [15:0] n);
    START   = 1'b1;
    SIZE_IN = n;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic waitReady(input string tag, input int target, input int budget);
    int c = 0;
    while (readyCount < target && c < budget) begin
      @(posedge CLK);
      #1;
      c++;
    end
    checkOutput(tag, (readyCount >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic waitOutputs(input string tag, input int target, input int budget);
    int c = 0;
    while (outQ.size() < target && c < budget) begin
      @(posedge CLK);
      #1;
      c++;
    end
    checkOutput(tag, (outQ.size() >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    SIZE_IN = '0;
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN_ENABLE = 1'b0;
    DATA_A_IN = '0;
    DATA_B_IN = '0;
    idleCycles(3);
    RST = 1'b0;
    idleCycles(1);
    checkOutput("reset_ready", READY, 0);
    checkOutput("reset_out_enable", DATA_OUT_ENABLE, 0);
    checkOutput("reset_div_zero", DIV_ZERO, 0);
    checkOutput("reset_data_out", DATA_OUT, 0);

    // Four elements, operands arriving together.
    base = outQ.size(); rbase = readyCount; wbase = readyWithOutCount;
    startVector(16'd4);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, vecA[k], 1'b1, vecB[k]);
    waitReady("v4_ready_seen", rbase + 1, 300);
    checkOutput("v4_count", outQ.size() - base, 4);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("v4_out%0d", k), outQ[base + k], vecQ[k]);
    checkOutput("v4_ready_with_last", readyWithOutCount - wbase, 1);
    checkOutput("v4_div_zero", DIV_ZERO, 0);

    // Six elements: one full batch, then a partial batch of two.
    base = outQ.size(); rbase = readyCount;
    startVector(16'd6);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, sixA[k], 1'b1, sixB[k]);
    waitOutputs("v6_first_batch", base + 4, 300);
    checkOutput("v6_no_early_ready", readyCount - rbase, 0);
    for (int k = 4; k < 6; k++) applyStimulus(1'b1, sixA[k], 1'b1, sixB[k]);
    waitReady("v6_ready_seen", rbase + 1, 300);
    idleCycles(5);
    checkOutput("v6_count", outQ.size() - base, 6);
    for (int k = 0; k < 6; k++) checkOutput($sformatf("v6_out%0d", k), outQ[base + k], sixQ[k]);
    checkOutput("v6_ready_pulses", readyCount - rbase, 1);

    // A leads B by three cycles, with a repeated A enable that must be dropped.
    base = outQ.size(); rbase = readyCount;
    startVector(16'd4);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, vecA[k], 1'b0, 16'h0000);
      applyStimulus(1'b1, 16'h7777, 1'b0, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b0, 16'h0000);
      applyStimulus(1'b0, 16'h0000, 1'b1, vecB[k]);
    end
    waitReady("skew_ready_seen", rbase + 1, 300);
    checkOutput("skew_count", outQ.size() - base, 4);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("skew_out%0d", k), outQ[base + k], vecQ[k]);

    // Zero divisors saturate according to the dividend sign.
    base = outQ.size(); rbase = readyCount;
    startVector(16'd2);
    applyStimulus(1'b1, 16'h0123, 1'b1, 16'h0000);
    applyStimulus(1'b1, 16'hFF00, 1'b1, 16'h0000);
    waitReady("dz_ready_seen", rbase + 1, 300);
    checkOutput("dz_count", outQ.size() - base, 2);
    checkOutput("dz_out_pos", outQ[base], 16'h7FFF);
    checkOutput("dz_out_neg", outQ[base + 1], 16'h8000);
    checkOutput("dz_flag", DIV_ZERO, 1);
    idleCycles(5);
    checkOutput("dz_flag_sticky", DIV_ZERO, 1);

    // Empty vector: READY one cycle later, no data, flag cleared by the START.
    base = outQ.size(); rbase = readyCount;
    startVector(16'd0);
    checkOutput("n0_ready", READY, 1);
    checkOutput("n0_out_enable", DATA_OUT_ENABLE, 0);
    checkOutput("n0_div_zero_cleared", DIV_ZERO, 0);
    idleCycles(1);
    checkOutput("n0_ready_pulse_ends", READY, 0);
    idleCycles(3);
    checkOutput("n0_no_outputs", outQ.size() - base, 0);
    checkOutput("n0_one_ready", readyCount - rbase, 1);

    // Reset in the middle of COMPUTE aborts the vector silently.
    base = outQ.size(); rbase = readyCount;
    startVector(16'd4);
    applyStimulus(1'b1, vecA[0], 1'b1, vecB[0]);
    applyStimulus(1'b1, vecA[1], 1'b1, 16'h0000);
    applyStimulus(1'b1, vecA[2], 1'b1, vecB[2]);
    applyStimulus(1'b1, vecA[3], 1'b1, vecB[3]);
    idleCycles(3);
    checkOutput("abort_in_compute", DIV_ZERO, 1);
    RST = 1'b1;
    #1;
    checkOutput("abort_data_out", DATA_OUT, 0);
    checkOutput("abort_out_enable", DATA_OUT_ENABLE, 0);
    checkOutput("abort_ready", READY, 0);
    checkOutput("abort_div_zero", DIV_ZERO, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idleCycles(40);
    checkOutput("abort_no_outputs", outQ.size() - base, 0);
    checkOutput("abort_no_ready", readyCount - rbase, 0);

    base = outQ.size(); rbase = readyCount;
    startVector(16'd4);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, vecA[k], 1'b1, vecB[k]);
    waitReady("rerun_ready_seen", rbase + 1, 300);
    checkOutput("rerun_count", outQ.size() - base, 4);
    for (int k = 0; k < 4; k++) checkOutput($sformatf("rerun_out%0d", k), outQ[base + k], vecQ[k]);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/model_vector_fixed_lane_divider.md
MODEL_VECTOR_FIXED_LANE_DIVIDER -- requirements
Module: model_vector_fixed_lane_divider

Interface
REQ-001 Parameter DATA_SIZE, default 64, operand/result width in bits (signed two's complement).
REQ-002 Parameter CONTROL_SIZE, default 64, width of element counters.
REQ-003 Parameter LANES, default 4, number of parallel scalar dividers; legal range 1..16.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 START  input  1  one-cycle request to begin a vector; SIZE_IN sampled in the same cycle.
REQ-007 READY  output  1  one-cycle pulse when the last result of the vector has been output.
REQ-008 DATA_A_IN_ENABLE  input  1  DATA_A_IN valid this cycle.
REQ-009 DATA_B_IN_ENABLE  input  1  DATA_B_IN valid this cycle.
REQ-010 DATA_OUT_ENABLE  output  1  DATA_OUT valid this cycle.
REQ-011 DIV_ZERO  output  1  sticky flag: at least one element of the current vector had B = 0.
REQ-012 SIZE_IN  input  DATA_SIZE  number of elements N in the vector.
REQ-013 DATA_A_IN / DATA_B_IN  input  DATA_SIZE  dividend / divisor element.
REQ-014 DATA_OUT  output  DATA_SIZE  quotient element, emitted in input order.

Function
REQ-015 FSM states: IDLE, LOAD, COMPUTE, DRAIN; reset state IDLE.
REQ-016 IDLE: START=1 latches N, clears element counters and DIV_ZERO, moves to LOAD; START outside IDLE is ignored.
REQ-017 IDLE with START=1 and N=0: READY pulses next cycle, no DATA_OUT_ENABLE, stays IDLE.
REQ-018 LOAD: A and B enables are independent; each is captured into the current slot's hold register; a slot is complete when both are held, including same-cycle arrival.
REQ-019 LOAD: enables arriving while the current slot already holds that operand are dropped.
REQ-020 LOAD ends when LANES slots are complete or total loaded count equals N; batch size K = min(LANES, remaining).
REQ-021 COMPUTE entry: each lane i<K with B != 0 receives a one-cycle START; lanes with B = 0 are not started, are marked done immediately, with result 2^(DATA_SIZE-1)-1 if A >= 0, else -2^(DATA_SIZE-1), and set DIV_ZERO.
REQ-022 COMPUTE: per-lane done flags latch each lane READY pulse; move to DRAIN when all K lanes are done.
REQ-023 DRAIN: output lane 0..K-1 results on consecutive cycles, DATA_OUT_ENABLE=1 each cycle; no back-pressure.
REQ-024 After the last batch result, READY=1 in the same cycle as its DATA_OUT_ENABLE; FSM returns to IDLE; otherwise return to LOAD.
REQ-025 DATA_OUT holds its last value when DATA_OUT_ENABLE=0; READY and DATA_OUT_ENABLE are single-cycle pulses.
REQ-026 Element counters are CONTROL_SIZE wide and never wrap within a legal N.
REQ-027 DIV_ZERO stays asserted until the next accepted START or reset.

Reset
REQ-028 RST forces immediately: FSM=IDLE, READY=0, DATA_OUT_ENABLE=0, DIV_ZERO=0, DATA_OUT=0, counters, hold registers and done flags cleared, lane STARTs low.
REQ-029 RST mid-vector discards all in-flight data; no READY is produced for the aborted vector; RST also drives every lane's reset.

Structure
REQ-030 FSM state encoding and ZERO/ONE control constants live in the shared package model_ntm_pkg.
REQ-031 LANES instances of the existing sub-module model_scalar_fixed_divider, generated by a loop; no other sub-modules.

Verification
REQ-032 DATA_SIZE=16, LANES=4, N=4, A={0x0400,0x0800,0xF800,0x0100}, B={0x0200,0x0400,0x0200,0x0100} same-cycle -> 4 outputs in order matching scalar model, READY with 4th, DIV_ZERO=0.
REQ-033 N=6, LANES=4 -> two batches (4 then 2), 6 in-order outputs, exactly one READY pulse.
REQ-034 A before B by 3 cycles per element, with duplicate A enable -> duplicate dropped, results identical to REQ-032.
REQ-035 Element A=0x0123,B=0 and A=0xFF00,B=0 -> outputs 0x7FFF and 0x8000, DIV_ZERO=1 until next START.
REQ-036 START with N=0 -> READY one cycle later, no DATA_OUT_ENABLE; RST asserted during COMPUTE -> all outputs 0 immediately, next START runs normally.
